// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin byte scheduler in front of a single UART transmitter
// Packet lock keeps multi-byte messages contiguous; baud code only changes between messages.
module uart_tx_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int GRANT_W       = 2,
  parameter int START_TIMEOUT = 16383
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [2:0]             cfg_baudset,
  output logic [7:0]             tx_data,
  output logic                   tx_transmit,
  output logic [2:0]             tx_baudset,
  input  logic                   tx_busy,
  output logic [GRANT_W-1:0]     grant_id,
  output logic                   lock_active,
  output logic                   sched_busy,
  output logic                   err_timeout
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [7:0]         data_q;
  logic               transmit_q;
  logic [2:0]         baud_q;
  logic [GRANT_W-1:0] grant_q;
  logic [GRANT_W-1:0] rr_ptr_q;
  logic               lock_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               found_d;
  logic [GRANT_W-1:0] win_d;
  logic [GRANT_W-1:0] idx_d;
  logic               accept_d;
  logic               baud_ok_d;
  logic [7:0]         sel_data_d;
  logic               sel_last_d;

  // Descending scan so the port closest after rr_ptr is the last one written and wins.
  always_comb begin
    found_d = 1'b0;
    win_d   = grant_q;
    idx_d   = '0;
    if (lock_q) begin
      found_d = req_valid[grant_q];
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx_d = GRANT_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (req_valid[idx_d]) begin
          found_d = 1'b1;
          win_d   = idx_d;
        end
      end
    end
  end

  always_comb begin
    accept_d   = (state_q == IDLE) && !tx_busy && !reset && found_d;
    req_ready  = accept_d ? (NUM_REQ'(1) << win_d) : '0;
    sel_data_d = req_data[8*win_d +: 8];
    sel_last_d = req_last[win_d];
    baud_ok_d  = (cfg_baudset == 3'b001) || (cfg_baudset == 3'b010) ||
                 (cfg_baudset == 3'b100);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= 8'h00;
      transmit_q <= 1'b0;
      baud_q     <= 3'b001;
      grant_q    <= '0;
      rr_ptr_q   <= GRANT_W'(NUM_REQ - 1);
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!lock_q && !tx_busy && baud_ok_d) begin
            baud_q <= cfg_baudset;
          end
          if (accept_d) begin
            data_q     <= sel_data_d;
            grant_q    <= win_d;
            rr_ptr_q   <= win_d;
            lock_q     <= !sel_last_d;
            transmit_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= START;
          end
        end
        START: begin
          if (tx_busy) begin
            transmit_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= WAIT_DONE;
          end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
            // Transmitter never answered: drop the byte and the message with it.
            err_q      <= 1'b1;
            transmit_q <= 1'b0;
            lock_q     <= 1'b0;
            cnt_q      <= '0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data     = data_q;
  assign tx_transmit = transmit_q && !reset;
  assign tx_baudset  = baud_q;
  assign grant_id    = grant_q;
  assign lock_active = lock_q;
  assign sched_busy  = (state_q != IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - vector table, directed corners and randomized traffic for uart_tx_scheduler
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [2:0]  cfg_baudset;
  logic [7:0]  tx_data;
  logic        tx_transmit;
  logic [2:0]  tx_baudset;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        lock_active;
  logic        sched_busy;
  logic        err_timeout;

  logic tx_auto, busy_auto, busy_man;
  assign tx_busy = tx_auto ? busy_auto : busy_man;

  uart_tx_scheduler #(.NUM_REQ(4), .GRANT_W(2), .START_TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .cfg_baudset(cfg_baudset),
    .tx_data(tx_data), .tx_transmit(tx_transmit), .tx_baudset(tx_baudset),
    .tx_busy(tx_busy), .grant_id(grant_id), .lock_active(lock_active),
    .sched_busy(sched_busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter stand-in: answers a start request after 0..2 cycles, stays busy 2..6 cycles.
  int busy_left = 0, dly = 0;
  bit pend = 0;
  initial begin
    busy_auto = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_auto) begin
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) busy_auto = 1'b0;
        end else begin
          if (!pend && tx_transmit) begin
            pend = 1;
            dly  = $urandom_range(0, 2);
          end
          if (pend) begin
            if (dly == 0) begin
              pend      = 0;
              busy_auto = 1'b1;
              busy_left = $urandom_range(2, 6);
            end else begin
              dly--;
            end
          end
        end
      end
    end
  end

  // Reference: spec arbitration rules over an abstract (rr, lock, grant) record.
  int   m_rr = 3, m_grant = 0;
  bit   m_lock = 0;
  bit   mon_en = 0;
  bit   exp_tx = 0;
  logic [7:0] exp_byte;
  int   exp_port;
  bit   exp_lock;
  logic [3:0] acc = 4'b0;

  function automatic int pred(input logic [3:0] v);
    int r = -1;
    if (m_lock) begin
      if (v[m_grant]) r = m_grant;
    end else begin
      for (int k = 1; k <= 4; k++)
        if (r < 0 && v[(m_rr + k) % 4]) r = (m_rr + k) % 4;
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_tx) begin
          chk("rnd_transmit", tx_transmit, 1);
          chk("rnd_tx_data", tx_data, exp_byte);
          chk("rnd_grant_id", grant_id, exp_port);
          chk("rnd_lock", lock_active, exp_lock);
          exp_tx = 0;
        end
        if (req_ready != 4'b0) begin
          int w;
          w = pred(req_valid);
          chk("rnd_winner", req_ready, (w < 0) ? 0 : (1 << w));
          chk("rnd_busy_low_at_accept", tx_busy, 0);
          acc = req_ready & req_valid;
          if (w >= 0) begin
            exp_tx   = 1;
            exp_byte = req_data[w*8 +: 8];
            exp_port = w;
            exp_lock = !req_last[w];
            m_rr     = w;
            m_grant  = w;
            m_lock   = !req_last[w];
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!sched_busy) break;
    end
    chk(name, sched_busy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 4'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic [2:0] cfg;
    logic [7:0] base;
    logic [1:0] exp_grant;
    logic       exp_lock;
    logic [2:0] exp_baud;
  } vec_t;

  vec_t tbl[15];

  logic [8:0] srcmem[4][16];
  int         head[4], len[4];

  initial begin
    bit ok;
    int tk;
    bit done;

    tbl[0]  = '{4'b1111, 4'b1111, 3'b001, 8'h3C, 2'd0, 1'b0, 3'b001};
    tbl[1]  = '{4'b1111, 4'b1111, 3'b001, 8'h51, 2'd1, 1'b0, 3'b001};
    tbl[2]  = '{4'b1111, 4'b1111, 3'b001, 8'h87, 2'd2, 1'b0, 3'b001};
    tbl[3]  = '{4'b1111, 4'b1111, 3'b001, 8'hE2, 2'd3, 1'b0, 3'b001};
    tbl[4]  = '{4'b1111, 4'b1111, 3'b001, 8'h09, 2'd0, 1'b0, 3'b001};
    tbl[5]  = '{4'b1111, 4'b1111, 3'b001, 8'h6D, 2'd1, 1'b0, 3'b001};
    tbl[6]  = '{4'b1111, 4'b1111, 3'b001, 8'hB4, 2'd2, 1'b0, 3'b001};
    tbl[7]  = '{4'b1111, 4'b1111, 3'b001, 8'hC7, 2'd3, 1'b0, 3'b001};
    tbl[8]  = '{4'b0001, 4'b1111, 3'b001, 8'h12, 2'd0, 1'b0, 3'b001};
    tbl[9]  = '{4'b0011, 4'b0000, 3'b001, 8'h40, 2'd1, 1'b1, 3'b001};
    tbl[10] = '{4'b0011, 4'b0000, 3'b100, 8'h41, 2'd1, 1'b1, 3'b001};
    tbl[11] = '{4'b0011, 4'b0010, 3'b100, 8'h42, 2'd1, 1'b0, 3'b100};
    tbl[12] = '{4'b0011, 4'b1111, 3'b011, 8'h9A, 2'd0, 1'b0, 3'b100};
    tbl[13] = '{4'b1000, 4'b1111, 3'b010, 8'h77, 2'd3, 1'b0, 3'b010};
    tbl[14] = '{4'b0100, 4'b1111, 3'b111, 8'hF0, 2'd2, 1'b0, 3'b010};

    reset = 1'b1; req_valid = 4'b0; req_data = 32'h0; req_last = 4'b0;
    cfg_baudset = 3'b001; tx_auto = 1'b1; busy_man = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_transmit", tx_transmit, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_baud", tx_baudset, 3'b001);
    chk("rst_grant", grant_id, 0);
    chk("rst_lock", lock_active, 0);
    chk("rst_sched_busy", sched_busy, 0);
    chk("rst_err", err_timeout, 0);

    for (int e = 0; e < 15; e++) begin
      @(posedge clk); #1;
      req_valid   = tbl[e].valid;
      req_last    = tbl[e].last;
      cfg_baudset = tbl[e].cfg;
      for (int p = 0; p < 4; p++) req_data[p*8 +: 8] = tbl[e].base ^ (8'h11 * 8'(p));
      wait_ready(ok);
      chk("tbl_ready", req_ready, 4'b0001 << tbl[e].exp_grant);
      @(posedge clk); #1;
      req_valid = 4'b0;
      @(negedge clk);
      chk("tbl_transmit", tx_transmit, 1);
      chk("tbl_tx_data", tx_data, tbl[e].base ^ (8'h11 * 8'(tbl[e].exp_grant)));
      chk("tbl_grant", grant_id, tbl[e].exp_grant);
      chk("tbl_lock", lock_active, tbl[e].exp_lock);
      wait_idle("tbl_idle");
      @(negedge clk);
      chk("tbl_baud", tx_baudset, tbl[e].exp_baud);
    end

    // Start timeout: transmitter never raises busy; locked message must be dropped.
    @(posedge clk); #1;
    tx_auto = 1'b0; busy_man = 1'b0;
    req_valid = 4'b0010; req_last = 4'b0000; req_data[15:8] = 8'h5E;
    wait_ready(ok);
    chk("to_ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0;
    for (tk = 0; tk < 40; tk++) begin
      @(negedge clk);
      if (tk == 0) begin
        chk("to_transmit_rise", tx_transmit, 1);
        chk("to_lock_set", lock_active, 1);
      end
      if (tk == 19) chk("to_transmit_held", tx_transmit, 1);
      if (err_timeout) break;
    end
    chk("to_cycle", tk, 20);
    chk("to_transmit_clr", tx_transmit, 0);
    chk("to_lock_clr", lock_active, 0);
    @(negedge clk);
    chk("to_err_pulse", err_timeout, 0);
    chk("to_idle", sched_busy, 0);

    // Reset while in WAIT_DONE with the lock held.
    @(posedge clk); #1;
    req_valid = 4'b1000; req_last = 4'b0000;
    wait_ready(ok);
    chk("rw_ready", req_ready, 4'b1000);
    @(posedge clk); #1;
    req_valid = 4'b0; busy_man = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_in_wait", sched_busy, 1);
    chk("rw_transmit_low", tx_transmit, 0);
    chk("rw_locked", lock_active, 1);
    @(posedge clk); #1;
    reset = 1'b1; busy_man = 1'b0; req_valid = 4'b1111; req_last = 4'b1111;
    @(negedge clk);
    chk("rw_ready_in_reset", req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_ready_in_reset2", req_ready, 0);
    chk("rw_grant", grant_id, 0);
    chk("rw_lock", lock_active, 0);
    chk("rw_sched_busy", sched_busy, 0);
    chk("rw_baud", tx_baudset, 3'b001);
    chk("rw_tx_data", tx_data, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rw_first_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0; tx_auto = 1'b1;
    wait_idle("rw_idle");

    // Randomized multi-port traffic against the reference model.
    do_reset();
    m_rr = 3; m_grant = 0; m_lock = 0; exp_tx = 0; acc = 4'b0;
    for (int p = 0; p < 4; p++) begin
      head[p] = 0;
      len[p]  = $urandom_range(4, 10);
      for (int j = 0; j < 16; j++)
        srcmem[p][j] = {($urandom_range(0, 2) == 0), 8'($urandom)};
      srcmem[p][len[p]-1][8] = 1'b1;
    end
    mon_en = 1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 4; p++) if (acc[p]) head[p]++;
      acc = 4'b0;
      done = 1;
      for (int p = 0; p < 4; p++) begin
        if (head[p] < len[p]) begin
          done = 0;
          req_valid[p]        = ($urandom_range(0, 3) != 0);
          req_data[p*8 +: 8]  = srcmem[p][head[p]][7:0];
          req_last[p]         = srcmem[p][head[p]][8];
        end else begin
          req_valid[p] = 1'b0;
        end
      end
      if (done) break;
    end
    wait_idle("rnd_idle");
    mon_en = 0;
    for (int p = 0; p < 4; p++) chk("rnd_drained", head[p], len[p]);
    chk("rnd_lock_end", lock_active, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
